pwm_sample_sequencer: RTL and testbench
=======================================

# pwm_sample_sequencer

Sample scheduler between the DDS phase/ROM stage and the PWM compare stage of the DDS generator. It buffers packed DDS words (two ROM_WIDTH samples per word) in a small FIFO and owns the PWM period counter. On every PWM period boundary it loads one sample into the compare shadow value, low half first, then high half. It provides startup priming, underrun detection and a per-word advance strobe back to the DDS.

## Interface
- ROM_WIDTH, 8, sample width; input word is 2*ROM_WIDTH.
- KPERIOD_COUNT, 255, PWM period terminal count (period = KPERIOD_COUNT+1 clocks).
- FIFO_DEPTH, 4, word buffer depth; power of two, ≥2.
- PRIME_LEVEL, 2, FIFO level required to start or restart; 1..FIFO_DEPTH.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  run enable; low forces IDLE.
- i_valid  in  1  input word valid.
- i_data  in  2*ROM_WIDTH  packed word; [ROM_WIDTH-1:0] played first.
- o_ready  out  1  FIFO not full.
- o_cmpa  out  ROM_WIDTH  compare shadow value to the PWM.
- o_load  out  1  one-cycle pulse: o_cmpa changed from a FIFO sample.
- o_prd_tick  out  1  high in the cycle the period counter equals KPERIOD_COUNT.
- o_ce  out  1  one-cycle pulse when a word is popped (DDS advance).
- o_underrun  out  1  sticky underrun flag.
- i_clr_err  in  1  clears o_underrun.
- o_state  out  2  current state, for debug.

## Operation
- States: IDLE=0, PRIME=1, RUN=2, UNDERRUN=3.
- IDLE: counter held at 0, FIFO flushed, phase=0, o_cmpa=2^(ROM_WIDTH-1) (midscale), o_ready=0. i_en=1 → PRIME.
- PRIME: counter runs, writes accepted. At a tick with level≥PRIME_LEVEL → RUN. The first load happens at that same tick.
- RUN: at each tick:
  - phase=0 and FIFO non-empty: o_cmpa←head[ROM_WIDTH-1:0], o_load, phase←1.
  - phase=1: o_cmpa←head[2*ROM_WIDTH-1:ROM_WIDTH], o_load, pop, o_ce, phase←0.
  - phase=0 and FIFO empty: o_cmpa holds, o_underrun←1, no o_load, → UNDERRUN.
- A word is never popped after only one half has been played.
- UNDERRUN: o_cmpa holds, writes accepted. At a tick with level≥PRIME_LEVEL → RUN and load as in RUN.
- i_en=0 in any state → IDLE on the next edge. This aborts the period and flushes the FIFO.
- Write occurs when i_valid&&o_ready. Levels are sampled before the edge, so a word written in a tick cycle is not visible at that tick.
- A write and a pop in the same cycle are both honoured; the level is unchanged.
- i_clr_err and a new underrun in the same cycle: the flag stays set.
- Counter counts 0..KPERIOD_COUNT and wraps to 0. Its width is clog2(KPERIOD_COUNT+1).

## Timing
- Reset values: counter=0, state=IDLE, phase=0, o_cmpa=midscale, o_load=0, o_ce=0, o_prd_tick=0, o_underrun=0, o_ready=0. FIFO is empty.
- All outputs are registered or decoded only from registers. No combinational path from inputs to outputs.
- o_ready is low in IDLE and otherwise = !full. It does not depend on the same-cycle pop.
- o_cmpa, o_load and o_ce update on the edge that ends the o_prd_tick cycle, so they are valid from counter=0.
- Minimum latency from first accepted word to first o_load: the next tick after level reaches PRIME_LEVEL.
- Steady state: o_ce pulses at most once per 2*(KPERIOD_COUNT+1) clocks.

## Structure
- Package pwm_seq_pkg holds:
  - the state encoding constants;
  - the midscale constant 2^(ROM_WIDTH-1);
  - a clog2 helper function.
- Sub-module sync_fifo (DEPTH, WIDTH parameters; push/pop/level/full/empty; flush input; async active-low reset). Reusable elsewhere in the library.
- Counter, phase bit and FSM live in pwm_sample_sequencer.

## Test plan
Benches use KPERIOD_COUNT=7, ROM_WIDTH=8, FIFO_DEPTH=4, PRIME_LEVEL=2.
- Reset: hold rst_n low mid-run → all outputs at reset values immediately. o_cmpa=0x80, o_state=0.
- Prime/run: enable, write 0x2211, 0x4433 → first tick after level=2 gives o_cmpa=0x11. Following ticks give 0x22, 0x33, 0x44. o_ce pulses after 0x22 and after 0x44; ticks are 8 clocks apart.
- Underrun: one word 0xBBAA played with no more writes → o_cmpa stays 0xBB. o_underrun=1 and state=3 at the next tick. Two new writes → RUN resumes at the following tick.
- Full/backpressure: hold i_valid=1 with PRIME blocked → o_ready drops after 4 accepted words. No data is lost, and playback order is correct.
- Disable mid-word: drop i_en after the low half of 0x5566 → IDLE, o_cmpa=0x80, FIFO empty. On re-enable, priming starts fresh.
- Flag clear: i_clr_err during an underrun tick → o_underrun stays 1. A clear in a later cycle → 0.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared types and helpers for the PWM sample sequencer.
// Holds the state encoding, the midscale value and a clog2 helper.
package pwm_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRIME    = 2'd1,
        ST_RUN      = 2'd2,
        ST_UNDERRUN = 2'd3
    } state_t;

    // Midscale compare value 2^(width-1) for a sample of the given width.
    function automatic int unsigned midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level, full/empty and synchronous flush.
// Ports: push/push_data in, pop in, head out, level/full/empty out.
module sync_fifo
    import pwm_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [clog2(DEPTH):0]      level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pwm_sample_sequencer.sv
// Feeds PWM compare values from buffered DDS words, one per period.
// Ports: i_en/i_valid/i_data/i_clr_err in; o_ready, o_cmpa, o_load,
// o_prd_tick, o_ce, o_underrun, o_state out.
module pwm_sample_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int unsigned ROM_WIDTH     = 8,
    parameter int unsigned KPERIOD_COUNT = 255,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned PRIME_LEVEL   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_en,
    input  logic                   i_valid,
    input  logic [2*ROM_WIDTH-1:0] i_data,
    output logic                   o_ready,
    output logic [ROM_WIDTH-1:0]   o_cmpa,
    output logic                   o_load,
    output logic                   o_prd_tick,
    output logic                   o_ce,
    output logic                   o_underrun,
    input  logic                   i_clr_err,
    output logic [1:0]             o_state
);

    localparam int unsigned CW_RAW = clog2(KPERIOD_COUNT + 1);
    localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam int unsigned LW     = clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0]        TERM = CW'(KPERIOD_COUNT);
    localparam logic [LW-1:0]        PLVL = LW'(PRIME_LEVEL);
    localparam logic [ROM_WIDTH-1:0] MID  = ROM_WIDTH'(midscale(ROM_WIDTH));

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic                   phase_q;
    logic [ROM_WIDTH-1:0]   cmpa_q;
    logic                   load_q;
    logic                   ce_q;
    logic                   unr_q;

    logic [2*ROM_WIDTH-1:0] head;
    logic [LW-1:0]          level;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   flush;
    logic                   tick;
    logic                   primed;
    logic                   load;
    logic                   unr_set;

    // Tick and ready decode only from registers.
    assign tick    = (state_q != ST_IDLE) && (cnt_q == TERM);
    assign primed  = (level >= PLVL);
    assign o_ready = (state_q != ST_IDLE) && !full;
    assign push    = i_valid && o_ready;
    assign flush   = (state_q == ST_IDLE) || !i_en;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * ROM_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (i_data),
        .pop       (pop),
        .head      (head),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        pop     = 1'b0;
        unr_set = 1'b0;
        if (!i_en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_PRIME;
                end
                ST_PRIME, ST_UNDERRUN: begin
                    // Phase is always 0 here, so restart plays a low half.
                    if (tick && primed) begin
                        state_d = ST_RUN;
                        load    = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        if (phase_q) begin
                            load = 1'b1;
                            pop  = 1'b1;
                        end else if (!empty) begin
                            load = 1'b1;
                        end else begin
                            unr_set = 1'b1;
                            state_d = ST_UNDERRUN;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            cmpa_q  <= MID;
            load_q  <= 1'b0;
            ce_q    <= 1'b0;
            unr_q   <= 1'b0;
        end else begin
            load_q <= load;
            ce_q   <= pop;
            if (!i_en || state_q == ST_IDLE) begin
                cnt_q   <= '0;
                phase_q <= 1'b0;
                cmpa_q  <= MID;
            end else begin
                cnt_q <= tick ? '0 : cnt_q + 1'b1;
                if (load) begin
                    phase_q <= ~phase_q;
                    cmpa_q  <= phase_q ? head[2*ROM_WIDTH-1:ROM_WIDTH]
                                       : head[ROM_WIDTH-1:0];
                end
            end
            // A new underrun wins over a same-cycle clear.
            if (unr_set) begin
                unr_q <= 1'b1;
            end else if (i_clr_err) begin
                unr_q <= 1'b0;
            end
        end
    end

    assign o_cmpa     = cmpa_q;
    assign o_load     = load_q;
    assign o_ce       = ce_q;
    assign o_prd_tick = tick;
    assign o_underrun = unr_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// Scoreboard bench for pwm_sample_sequencer (period 8 clocks).
// Directed words push expected samples; a monitor checks each load.
module tb_pwm_sample_sequencer;

    typedef struct {
        logic [7:0] v;
        logic       ce;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_en = 1'b0;
    logic        i_valid = 1'b0;
    logic [15:0] i_data = '0;
    logic        i_clr_err = 1'b0;
    logic        o_ready;
    logic [7:0]  o_cmpa;
    logic        o_load;
    logic        o_prd_tick;
    logic        o_ce;
    logic        o_underrun;
    logic [1:0]  o_state;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_tick = -1;

    pwm_sample_sequencer #(
        .ROM_WIDTH     (8),
        .KPERIOD_COUNT (7),
        .FIFO_DEPTH    (4),
        .PRIME_LEVEL   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (i_en),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .o_cmpa     (o_cmpa),
        .o_load     (o_load),
        .o_prd_tick (o_prd_tick),
        .o_ce       (o_ce),
        .o_underrun (o_underrun),
        .i_clr_err  (i_clr_err),
        .o_state    (o_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [15:0] w);
        int n = 0;
        while (!o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("put_ready", o_ready, 1);
        if (o_ready) begin
            sb.push_back('{w[7:0], 1'b0});
            sb.push_back('{w[15:8], 1'b1});
            i_valid = 1'b1;
            i_data  = w;
            @(negedge clk);
            i_valid = 1'b0;
        end
    endtask

    task automatic wait_q(input int target);
        int n = 0;
        while (sb.size() > target && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("sb_drain", sb.size(), target);
    endtask

    task automatic wait_tick();
        int n = 0;
        while (!o_prd_tick && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tick_seen", o_prd_tick, 1);
    endtask

    // Monitor: every load is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (o_state == 2'd0) last_tick = -1;
        if (o_prd_tick) begin
            if (last_tick >= 0) check("tick_gap", cyc - last_tick, 8);
            last_tick = cyc;
        end
        if (o_load) begin
            if (sb.size() == 0) begin
                check("load_unexpected", o_load, 0);
            end else begin
                e = sb.pop_front();
                check("cmpa", o_cmpa, e.v);
                check("ce", o_ce, e.ce);
            end
        end else if (o_ce) begin
            check("ce_no_load", o_ce, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cmpa", o_cmpa, 8'h80);
        check("rst_state", o_state, 0);
        check("rst_ready", o_ready, 0);
        check("rst_load", o_load, 0);
        check("rst_ce", o_ce, 0);
        check("rst_tick", o_prd_tick, 0);
        check("rst_unr", o_underrun, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Prime and run, then a single-word tail into underrun.
        i_en = 1'b1;
        @(negedge clk);
        check("prime_state", o_state, 1);
        check("prime_ready", o_ready, 1);
        put(16'h2211);
        put(16'h4433);
        wait_q(3);
        check("run_state", o_state, 2);
        put(16'hBBAA);
        wait_q(0);

        // Underrun tick with a concurrent clear: flag must stay set.
        wait_tick();
        check("unr_pre", o_underrun, 0);
        i_clr_err = 1'b1;
        @(negedge clk);
        check("unr_set", o_underrun, 1);
        check("unr_state", o_state, 3);
        check("unr_hold", o_cmpa, 8'hBB);
        check("unr_noload", o_load, 0);
        @(negedge clk);
        i_clr_err = 1'b0;
        check("unr_clr", o_underrun, 0);

        put(16'h1234);
        put(16'h5678);
        wait_q(3);
        check("resume_state", o_state, 2);
        wait_q(0);

        // Backpressure: fill during a fresh prime period.
        i_en = 1'b0;
        @(negedge clk);
        check("dis_state", o_state, 0);
        i_en = 1'b1;
        @(negedge clk);
        check("bp_state", o_state, 1);
        put(16'h0201);
        put(16'h0403);
        put(16'h0605);
        put(16'h0807);
        check("bp_full", o_ready, 0);
        check("bp_prime", o_state, 1);
        put(16'h0A09);
        wait_q(0);

        // Disable after the low half of 0x5566.
        put(16'h5566);
        put(16'h7788);
        wait_q(3);
        check("mid_low", o_cmpa, 8'h66);
        i_en = 1'b0;
        @(negedge clk);
        sb.delete();
        check("off_state", o_state, 0);
        check("off_cmpa", o_cmpa, 8'h80);
        check("off_ready", o_ready, 0);
        check("off_load", o_load, 0);
        i_en = 1'b1;
        @(negedge clk);
        check("re_state", o_state, 1);
        put(16'hA1B2);
        wait_tick();
        @(negedge clk);
        check("re_hold1", o_state, 1);
        check("re_mid", o_cmpa, 8'h80);
        wait_tick();
        @(negedge clk);
        check("re_hold2", o_state, 1);
        put(16'hC3D4);
        wait_q(2);

        // Asynchronous reset mid-run.
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("arst_cmpa", o_cmpa, 8'h80);
        check("arst_state", o_state, 0);
        check("arst_ready", o_ready, 0);
        check("arst_load", o_load, 0);
        check("arst_ce", o_ce, 0);
        check("arst_tick", o_prd_tick, 0);
        check("arst_unr", o_underrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
